// File: rtl/mem_pkg.sv
// Shared load/store definitions: func3 width codes, completion codes, FSM states
// and the func3 legality check used by the access unit.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Double and unsigned-word accesses only exist on a 64-bit datapath.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                    input logic wide);
    if (is_store)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (wide && (f3 == F3_D));
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) ||
           (f3 == F3_HU) || (wide && ((f3 == F3_D) || (f3 == F3_WU)));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lanes of a memory word and sign/zero-extends them
// according to the load func3.
module load_extend #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]             mem_rd,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [2:0]                  func3,
  output logic [XLEN-1:0]             rdata
);

  logic [XLEN-1:0] sh;
  logic            top;
  logic            sbit;
  int unsigned     nbits;

  always_comb begin
    sh    = mem_rd >> {offset, 3'b000};
    nbits = 32'd8 << func3[1:0];
    if (nbits > XLEN) nbits = XLEN;
    case (func3[1:0])
      2'd0:    top = sh[7];
      2'd1:    top = sh[15];
      2'd2:    top = sh[31];
      default: top = sh[XLEN-1];
    endcase
    sbit = ~func3[2] & top;
    for (int unsigned i = 0; i < XLEN; i++)
      rdata[i] = (i < nbits) ? sh[i] : sbit;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine: decodes func3, checks alignment, drives a req/ack memory
// handshake with optional timeout and returns extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                we,
  input  logic [2:0]          func3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [XLEN-1:0]     wdata,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code,
  output logic [XLEN-1:0]     rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_adr,
  output logic [XLEN-1:0]     mem_wd,
  input  logic [XLEN-1:0]     mem_rd,
  input  logic                mem_ack
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OFS = $clog2(NB);
  localparam int unsigned CW  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_t          state;
  logic            lwe;
  logic [2:0]      lf3;
  logic [OFS-1:0]  loff;
  logic [CW-1:0]   wcnt;

  logic [OFS-1:0]  in_off;
  logic [OFS-1:0]  align_mask;
  logic            in_legal;
  logic            in_mis;
  logic [NB-1:0]   bmask;
  logic [NB-1:0]   be_in;
  logic [XLEN-1:0] wmask;
  logic [XLEN-1:0] wd_in;
  logic [XLEN-1:0] ext;

  always_comb begin
    in_off   = addr[OFS-1:0];
    in_legal = f3_legal(we, func3, XLEN == 64);
    case (func3[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OFS'(1);
      2'd2:    align_mask = OFS'(3);
      default: align_mask = OFS'(7);
    endcase
    in_mis = (in_off & align_mask) != '0;
    for (int unsigned i = 0; i < NB; i++)
      bmask[i] = i < (32'd1 << func3[1:0]);
    for (int unsigned i = 0; i < XLEN; i++)
      wmask[i] = i < (32'd8 << func3[1:0]);
    be_in = bmask << in_off;
    wd_in = (wdata & wmask) << {in_off, 3'b000};
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .mem_rd (mem_rd),
    .offset (loff),
    .func3  (lf3),
    .rdata  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_code <= ERR_OK;
      rdata    <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_be   <= '0;
      mem_adr  <= '0;
      mem_wd   <= '0;
      lwe      <= 1'b0;
      lf3      <= '0;
      loff     <= '0;
      wcnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lwe  <= we;
            lf3  <= func3;
            loff <= in_off;
            wcnt <= '0;
            if (!in_legal) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else if (in_mis) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              err_code <= ERR_MISALIGN;
            end else begin
              state   <= ST_ACCESS;
              busy    <= 1'b1;
              mem_req <= 1'b1;
              mem_we  <= we;
              mem_be  <= be_in;
              mem_adr <= {addr[ADDR_W-1:OFS], {OFS{1'b0}}};
              mem_wd  <= we ? wd_in : '0;
            end
          end
        end
        ST_ACCESS: begin
          // Ack is checked before the timeout so a last-cycle ack still succeeds.
          if (mem_ack) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            mem_req  <= 1'b0;
            err_code <= ERR_OK;
            if (!lwe) rdata <= ext;
          end else if ((MAX_WAIT != 0) && (wcnt == TO_LAST)) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            mem_req  <= 1'b0;
            err_code <= ERR_TIMEOUT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store engine between the multi-cycle datapath (address, store data, MDR capture) and data memory.
- Adds capabilities the current datapath lacks: byte/half/word/double access by func3, byte enables, sign/zero extension, a req/ack handshake with wait states, misalignment and illegal-op detection, and a wait timeout.
- The controller pulses start and waits for done.

Parameters:
- XLEN, 32, data width (32 or 64); NB = XLEN/8 byte lanes; OFS = log2(NB).
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 15, maximum wait cycles for ack before timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request from the controller; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- func3  in  3  RISC-V width/sign code.
- addr  in  ADDR_W  byte address.
- wdata  in  XLEN  store data (rs2).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  00 ok, 01 misaligned, 10 illegal func3, 11 timeout; valid while done=1, held until the next done.
- rdata  out  XLEN  extended load data; updates only on an ok load.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_be  out  NB  byte enables.
- mem_adr  out  ADDR_W  word-aligned address (addr with low OFS bits cleared).
- mem_wd  out  XLEN  lane-shifted store data.
- mem_rd  in  XLEN  read data; valid with mem_ack.
- mem_ack  in  1  access complete.

Behaviour:
- Reset: state=IDLE; busy, done, mem_req, mem_we, mem_be, mem_adr, mem_wd = 0; err_code=00; rdata=0; wait counter=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - start=1 latches we, func3, addr, wdata.
  - Illegal func3 -> DONE with err 10.
  - Else misaligned -> DONE with err 01.
  - Else -> ACCESS.
  - In both error cases mem_req is never asserted.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; XLEN=64 adds 011 LD, 110 LWU.
- Legal stores: 000 SB, 001 SH, 010 SW; XLEN=64 adds 011 SD.
- Misaligned: the access size does not divide addr[OFS-1:0].
- ACCESS:
  - mem_req=1 and all mem_* outputs are stable (registered from the latched values).
  - Byte enables: size-wide ones, shifted left by the offset.
  - mem_wd: low size bytes of wdata shifted left by offset*8; other lanes 0.
  - Wait counter increments each cycle without ack.
  - mem_ack=1 -> DONE with err 00; for a load, rdata <= extended lanes of mem_rd.
  - Counter reaches MAX_WAIT (MAX_WAIT != 0) without ack -> DONE with err 11; rdata is unchanged.
  - Ack and timeout in the same cycle: ack wins.
- DONE: done=1 for one cycle, mem_req=0, busy=0, then IDLE.
- start while busy or in DONE: ignored, not queued.
- Latency:
  - start at edge t -> mem_req from cycle t+1.
  - Ack sampled at edge t+k -> done in cycle t+k+1.
  - Zero-wait access (ack in the first ACCESS cycle): done 2 cycles after start.
  - Error path: done 1 cycle after start.
- mem_ack outside ACCESS: ignored.
- Reset mid-ACCESS: mem_req drops at the next edge; no done; a late ack is ignored.

Decomposition:
- Shared package mem_pkg:
  - func3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - err_code constants.
  - FSM state enum.
- Combinational sub-module load_extend (mem_rd, offset, func3 -> extended rdata). Instantiated once; reusable by the datapath.

Test Plan:
- XLEN=32. LW at addr 0x100, mem_ack in the first ACCESS cycle, mem_rd=0xDEADBEEF -> mem_adr=0x100, mem_be=1111, done 2 cycles after start, err 00, rdata=0xDEADBEEF.
- LB at addr 0x103 with mem_rd=0x80112233, then LBU at the same address -> mem_be=1000; rdata=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH at addr 0x202 with wdata=0x0000ABCD, ack delayed 3 cycles -> mem_we=1, mem_be=1100, mem_wd=0xABCD0000, mem_req high for 4 cycles, done on the next cycle.
- LW at addr 0x101 -> err 01 one cycle after start, mem_req never high, rdata unchanged. func3=011 with XLEN=32 -> err 10.
- MAX_WAIT=4, no ack -> mem_req high for 4 cycles, done with err 11. Repeat with ack in the final cycle -> err 00.
- rst asserted in the 2nd ACCESS cycle, then ack the following cycle -> all outputs 0, no done pulse. A subsequent LW completes normally.
